// File: rtl/shim_spi_cfg_sync_if.sv
// Config/status bundle between the AXI config register block and the SPI-domain config shim.
// The master drives the raw AXI-domain config; the slave returns the settled SPI-domain copies.
interface shim_spi_cfg_sync_if;
  logic        spi_en;
  logic        integ_en;
  logic [14:0] integ_thresh_avg;
  logic [31:0] integ_window;
  logic [7:0]  dac_n_cs_high_time;
  logic [7:0]  adc_n_cs_high_time;

  logic        spi_en_stable;
  logic        integ_en_stable;
  logic [14:0] integ_thresh_avg_stable;
  logic [31:0] integ_window_stable;
  logic [7:0]  dac_n_cs_high_time_stable;
  logic [7:0]  adc_n_cs_high_time_stable;
  logic        cfg_locked;
  logic        cfg_change_err;

  modport master (
    output spi_en,
    output integ_en,
    output integ_thresh_avg,
    output integ_window,
    output dac_n_cs_high_time,
    output adc_n_cs_high_time,
    input  spi_en_stable,
    input  integ_en_stable,
    input  integ_thresh_avg_stable,
    input  integ_window_stable,
    input  dac_n_cs_high_time_stable,
    input  adc_n_cs_high_time_stable,
    input  cfg_locked,
    input  cfg_change_err
  );

  modport slave (
    input  spi_en,
    input  integ_en,
    input  integ_thresh_avg,
    input  integ_window,
    input  dac_n_cs_high_time,
    input  adc_n_cs_high_time,
    output spi_en_stable,
    output integ_en_stable,
    output integ_thresh_avg_stable,
    output integ_window_stable,
    output dac_n_cs_high_time_stable,
    output adc_n_cs_high_time_stable,
    output cfg_locked,
    output cfg_change_err
  );
endinterface

// File: rtl/shim_spi_cfg_sync.sv
// Carries AXI-domain SPI configuration into the spi_clk domain: per-field synchronizers,
// per-field stability filters and a lock FSM that freezes config while the SPI system runs.
module shim_spi_cfg_sync #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned STABLE_COUNT = 2
) (
  input logic                spi_clk,
  input logic                spi_resetn,
  shim_spi_cfg_sync_if.slave cfg
);

  localparam int unsigned NumFields = 6;
  localparam int unsigned BusW      = 65;
  localparam int unsigned CntW      = $clog2(STABLE_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_COUNT);

  // Packed bus layout: {adc[64:57], dac[56:49], window[48:17], thresh[16:2], integ_en[1], spi_en[0]}
  localparam logic [BusW-1:0] MaskSpiEn   = {{(BusW - 1){1'b0}}, 1'b1};
  localparam logic [BusW-1:0] MaskIntegEn = {{(BusW - 2){1'b0}}, 1'b1, 1'b0};
  localparam logic [BusW-1:0] MaskThresh  = {{(BusW - 17){1'b0}}, {15{1'b1}}, 2'b00};
  localparam logic [BusW-1:0] MaskWindow  = {{(BusW - 49){1'b0}}, {32{1'b1}}, 17'd0};
  localparam logic [BusW-1:0] MaskDac     = {{(BusW - 57){1'b0}}, 8'hff, 49'd0};
  localparam logic [BusW-1:0] MaskAdc     = {8'hff, 57'd0};
  localparam logic [BusW-1:0] FieldMask [NumFields] = '{
    MaskSpiEn, MaskIntegEn, MaskThresh, MaskWindow, MaskDac, MaskAdc
  };

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } state_e;

  logic [BusW-1:0]      in_bus;
  logic [BusW-1:0]      sync_q [DEPTH];
  logic [BusW-1:0]      sync;
  logic [BusW-1:0]      sync_nxt;
  logic [CntW-1:0]      cnt_q [NumFields];
  logic [CntW-1:0]      cnt_d [NumFields];
  logic [NumFields-1:0] settled;
  logic [NumFields-1:0] mismatch;
  logic [BusW-1:1]      load_mask;
  logic                 en_settled_hi;
  logic                 en_settled_lo;
  logic                 cfg_all_settled;

  state_e               state_q;
  logic [BusW-1:1]      cfg_q;
  logic                 spi_en_stable_q;
  logic                 cfg_locked_q;
  logic                 cfg_change_err_q;

  assign in_bus = {cfg.adc_n_cs_high_time, cfg.dac_n_cs_high_time, cfg.integ_window,
                   cfg.integ_thresh_avg, cfg.integ_en, cfg.spi_en};

  // sync_nxt is the value the last stage takes on this edge; comparing against it lets the
  // counter restart on the same edge the synchronized word changes.
  assign sync     = sync_q[DEPTH-1];
  assign sync_nxt = sync_q[DEPTH-2];

  always_comb begin
    cnt_d     = cnt_q;
    settled   = '0;
    mismatch  = '0;
    load_mask = '0;
    for (int unsigned i = 0; i < NumFields; i++) begin
      settled[i] = (cnt_q[i] == CntMax);
      if (|((sync ^ sync_nxt) & FieldMask[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (i != 0 && settled[i]) begin
        mismatch[i] = |((sync[BusW-1:1] ^ cfg_q) & FieldMask[i][BusW-1:1]);
        load_mask   = load_mask | FieldMask[i][BusW-1:1];
      end
    end
  end

  assign en_settled_hi   = settled[0] & sync[0];
  assign en_settled_lo   = settled[0] & ~sync[0];
  assign cfg_all_settled = &settled[NumFields-1:1];

  always_ff @(posedge spi_clk) begin
    if (!spi_resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sync_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NumFields; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_bus;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      for (int unsigned i = 0; i < NumFields; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Status outputs follow the state one edge later so they change with the config they guard.
  always_ff @(posedge spi_clk) begin
    if (!spi_resetn) begin
      state_q          <= StUnlocked;
      cfg_q            <= '0;
      spi_en_stable_q  <= 1'b0;
      cfg_locked_q     <= 1'b0;
      cfg_change_err_q <= 1'b0;
    end else begin
      spi_en_stable_q <= (state_q == StLocked);
      cfg_locked_q    <= (state_q == StLocked);
      unique case (state_q)
        StUnlocked: begin
          cfg_q            <= (cfg_q & ~load_mask) | (sync[BusW-1:1] & load_mask);
          cfg_change_err_q <= 1'b0;
          if (en_settled_hi && cfg_all_settled) begin
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (en_settled_lo) begin
            state_q          <= StUnlocked;
            cfg_change_err_q <= 1'b0;
          end else if (|mismatch) begin
            cfg_change_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StUnlocked;
        end
      endcase
    end
  end

  assign cfg.spi_en_stable             = spi_en_stable_q;
  assign cfg.integ_en_stable           = cfg_q[1];
  assign cfg.integ_thresh_avg_stable   = cfg_q[16:2];
  assign cfg.integ_window_stable       = cfg_q[48:17];
  assign cfg.dac_n_cs_high_time_stable = cfg_q[56:49];
  assign cfg.adc_n_cs_high_time_stable = cfg_q[64:57];
  assign cfg.cfg_locked                = cfg_locked_q;
  assign cfg.cfg_change_err            = cfg_change_err_q;

endmodule

// File: tb/tb_shim_spi_cfg_sync.sv
// Bench for shim_spi_cfg_sync: directed latency table, lock/unlock/reset sequences, then random
// stimulus compared every cycle against a history-based reference model.
module tb_shim_spi_cfg_sync;

  localparam int Depth       = 3;
  localparam int StableCount = 2;

  typedef struct packed {
    logic        en;
    logic        ie;
    logic [14:0] th;
    logic [31:0] w;
    logic [7:0]  d;
    logic [7:0]  a;
  } cfg_t;

  typedef struct {
    cfg_t in;
    cfg_t exp;
    int   lat;
  } vec_t;

  logic spi_clk;
  logic spi_resetn;
  shim_spi_cfg_sync_if bus();

  shim_spi_cfg_sync #(
    .DEPTH       (Depth),
    .STABLE_COUNT(StableCount)
  ) dut (
    .spi_clk   (spi_clk),
    .spi_resetn(spi_resetn),
    .cfg       (bus)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw input samples since the last reset, plus spec-level FSM state.
  cfg_t        hist[$];
  bit          m_state;
  logic        m_en_st;
  logic        m_lock;
  logic        m_err;
  logic [31:0] m_cfg [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input cfg_t c, input int f);
    case (f)
      0:       return {31'd0, c.en};
      1:       return {31'd0, c.ie};
      2:       return {17'd0, c.th};
      3:       return c.w;
      4:       return {24'd0, c.d};
      5:       return {24'd0, c.a};
      default: return '0;
    endcase
  endfunction

  // Synchronized value j edges after reset: the input sampled Depth-1 edges earlier, else 0.
  function automatic logic [31:0] sync_at(input int j, input int f);
    int idx;
    idx = j - Depth;
    if (idx < 0) return '0;
    return fld(hist[idx], f);
  endfunction

  task automatic model_step();
    logic [31:0] sv [6];
    bit          st [6];
    bit          all_cfg;
    bit          mis;
    int          n;
    cfg_t        s;
    if (!spi_resetn) begin
      hist.delete();
      m_state = 1'b0;
      m_en_st = 1'b0;
      m_lock  = 1'b0;
      m_err   = 1'b0;
      for (int f = 0; f < 6; f++) m_cfg[f] = '0;
      return;
    end
    n       = hist.size();
    all_cfg = 1'b1;
    mis     = 1'b0;
    for (int f = 0; f < 6; f++) begin
      sv[f] = sync_at(n, f);
      st[f] = (n >= StableCount);
      for (int k = n - StableCount; k < n; k++) begin
        if (k >= 0 && sync_at(k, f) != sv[f]) st[f] = 1'b0;
      end
      if (f > 0) begin
        if (!st[f]) all_cfg = 1'b0;
        if (st[f] && sv[f] != m_cfg[f]) mis = 1'b1;
      end
    end
    m_en_st = m_state;
    m_lock  = m_state;
    if (!m_state) begin
      for (int f = 1; f < 6; f++) if (st[f]) m_cfg[f] = sv[f];
      m_err = 1'b0;
      if (st[0] && sv[0][0] && all_cfg) m_state = 1'b1;
    end else if (st[0] && !sv[0][0]) begin
      m_state = 1'b0;
      m_err   = 1'b0;
    end else if (mis) begin
      m_err = 1'b1;
    end
    s.en = bus.spi_en;
    s.ie = bus.integ_en;
    s.th = bus.integ_thresh_avg;
    s.w  = bus.integ_window;
    s.d  = bus.dac_n_cs_high_time;
    s.a  = bus.adc_n_cs_high_time;
    hist.push_back(s);
  endtask

  // One spi_clk edge; the model advances on the edge, outputs are read on the falling edge.
  task automatic tick();
    @(posedge spi_clk);
    model_step();
    @(negedge spi_clk);
  endtask

  task automatic drive_cfg(input cfg_t c);
    bus.integ_en           = c.ie;
    bus.integ_thresh_avg   = c.th;
    bus.integ_window       = c.w;
    bus.dac_n_cs_high_time = c.d;
    bus.adc_n_cs_high_time = c.a;
  endtask

  task automatic chk_cfg(input string pfx, input cfg_t e);
    chk({pfx, "_integ_en"},  bus.integ_en_stable,           e.ie);
    chk({pfx, "_thresh"},    bus.integ_thresh_avg_stable,   e.th);
    chk({pfx, "_window"},    bus.integ_window_stable,       e.w);
    chk({pfx, "_dac"},       bus.dac_n_cs_high_time_stable, e.d);
    chk({pfx, "_adc"},       bus.adc_n_cs_high_time_stable, e.a);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_cfg(pfx, '0);
    chk({pfx, "_spi_en_stable"}, bus.spi_en_stable,  1'b0);
    chk({pfx, "_cfg_locked"},    bus.cfg_locked,     1'b0);
    chk({pfx, "_change_err"},    bus.cfg_change_err, 1'b0);
  endtask

  task automatic chk_model(input int c);
    chk($sformatf("rnd%0d_spi_en_stable", c), bus.spi_en_stable,             m_en_st);
    chk($sformatf("rnd%0d_cfg_locked", c),    bus.cfg_locked,                m_lock);
    chk($sformatf("rnd%0d_change_err", c),    bus.cfg_change_err,            m_err);
    chk($sformatf("rnd%0d_integ_en", c),      bus.integ_en_stable,           m_cfg[1]);
    chk($sformatf("rnd%0d_thresh", c),        bus.integ_thresh_avg_stable,   m_cfg[2]);
    chk($sformatf("rnd%0d_window", c),        bus.integ_window_stable,       m_cfg[3]);
    chk($sformatf("rnd%0d_dac", c),           bus.dac_n_cs_high_time_stable, m_cfg[4]);
    chk($sformatf("rnd%0d_adc", c),           bus.adc_n_cs_high_time_stable, m_cfg[5]);
  endtask

  vec_t vecs [4];
  cfg_t prev;
  bit   seen;

  initial begin
    vecs[0] = '{in: '{en: 0, ie: 0, th: 15'h0000, w: 32'h0001_2345, d: 8'h00, a: 8'h00},
                exp: '{en: 0, ie: 0, th: 15'h0000, w: 32'h0001_2345, d: 8'h00, a: 8'h00}, lat: 6};
    vecs[1] = '{in: '{en: 0, ie: 1, th: 15'h7fff, w: 32'hdead_beef, d: 8'hff, a: 8'h01},
                exp: '{en: 0, ie: 1, th: 15'h7fff, w: 32'hdead_beef, d: 8'hff, a: 8'h01}, lat: 6};
    vecs[2] = '{in: '{en: 0, ie: 0, th: 15'h0001, w: 32'hdead_beef, d: 8'h5a, a: 8'ha5},
                exp: '{en: 0, ie: 0, th: 15'h0001, w: 32'hdead_beef, d: 8'h5a, a: 8'ha5}, lat: 6};
    vecs[3] = '{in: '{en: 0, ie: 1, th: 15'h1234, w: 32'h0001_2345, d: 8'h03, a: 8'h04},
                exp: '{en: 0, ie: 1, th: 15'h1234, w: 32'h0001_2345, d: 8'h03, a: 8'h04}, lat: 6};

    spi_resetn = 1'b0;
    bus.spi_en = 1'b0;
    drive_cfg('0);
    repeat (10) tick();
    chk_all_zero("reset");
    spi_resetn = 1'b1;
    repeat (3) tick();

    // Unlocked tracking: each step must land exactly at its latency, not one edge earlier.
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      drive_cfg(vecs[i].in);
      for (int e = 1; e <= vecs[i].lat; e++) begin
        tick();
        if (e == vecs[i].lat - 1) chk_cfg($sformatf("vec%0d_early", i), prev);
      end
      chk_cfg($sformatf("vec%0d_lat", i), vecs[i].exp);
      chk($sformatf("vec%0d_unlocked", i), bus.cfg_locked, 1'b0);
      prev = vecs[i].exp;
      repeat (2) tick();
    end

    // Lock with thresh 0x1234 settled.
    bus.spi_en = 1'b1;
    repeat (6) tick();
    chk("lock_early_en_stable", bus.spi_en_stable, 1'b0);
    chk("lock_early_locked",    bus.cfg_locked,    1'b0);
    tick();
    chk("lock_en_stable", bus.spi_en_stable, 1'b1);
    chk("lock_locked",    bus.cfg_locked,    1'b1);

    bus.integ_thresh_avg = 15'h0555;
    repeat (5) tick();
    chk("err_early", bus.cfg_change_err, 1'b0);
    tick();
    chk("err_set",       bus.cfg_change_err,          1'b1);
    chk("locked_thresh", bus.integ_thresh_avg_stable, 15'h1234);

    bus.spi_en = 1'b0;
    repeat (6) tick();
    chk("unlock_early_en_stable", bus.spi_en_stable,           1'b1);
    chk("unlock_err_cleared",     bus.cfg_change_err,          1'b0);
    chk("unlock_early_thresh",    bus.integ_thresh_avg_stable, 15'h1234);
    tick();
    chk("unlock_en_stable", bus.spi_en_stable,           1'b0);
    chk("unlock_locked",    bus.cfg_locked,              1'b0);
    chk("unlock_thresh",    bus.integ_thresh_avg_stable, 15'h0555);
    chk("unlock_err",       bus.cfg_change_err,          1'b0);

    // Single-cycle spi_en glitch must never surface.
    seen = 1'b0;
    bus.spi_en = 1'b1;
    tick();
    bus.spi_en = 1'b0;
    repeat (15) begin
      tick();
      if (bus.spi_en_stable || bus.cfg_locked) seen = 1'b1;
    end
    chk("glitch_no_enable", seen, 1'b0);

    // Window toggling every 2 cycles never settles.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.integ_window = (i % 2 == 0) ? 32'haaaa_0000 : 32'h5555_0000;
      repeat (2) begin
        tick();
        if (bus.integ_window_stable !== 32'h0001_2345) seen = 1'b1;
      end
    end
    bus.integ_window = 32'h0001_2345;
    repeat (8) begin
      tick();
      if (bus.integ_window_stable !== 32'h0001_2345) seen = 1'b1;
    end
    chk("toggle_no_update", seen, 1'b0);

    // Relock, then one-edge reset while locked.
    bus.spi_en = 1'b1;
    repeat (7) tick();
    chk("relock_locked", bus.cfg_locked, 1'b1);
    spi_resetn = 1'b0;
    tick();
    chk_all_zero("midrst");
    spi_resetn = 1'b1;
    repeat (6) tick();
    chk("rst_relock_early", bus.spi_en_stable, 1'b0);
    tick();
    chk("rst_relock_en_stable", bus.spi_en_stable,           1'b1);
    chk("rst_relock_locked",    bus.cfg_locked,              1'b1);
    chk("rst_relock_thresh",    bus.integ_thresh_avg_stable, 15'h0555);

    // Random phase against the reference model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk_model(c);
      spi_resetn = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 24) == 0) bus.spi_en = ~bus.spi_en;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(1, 5))
          1:       bus.integ_en = ~bus.integ_en;
          2:       bus.integ_thresh_avg = 15'($urandom);
          3:       bus.integ_window = $urandom;
          4:       bus.dac_n_cs_high_time = 8'($urandom);
          default: bus.adc_n_cs_high_time = 8'($urandom);
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
